multi_cycle_ctrl: RTL and testbench

Control-unit FSM for the multi-cycle CPU datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states. Generates the program-counter write enable and next-PC select that drive the PC register, plus all datapath enables and mux selects. Sits between the instruction register (opcode source) and the PC / register file / ALU / data memory.

---
 rtl/ctrl_pkg.sv | 51 +++++
 rtl/ctrl_decode.sv | 47 ++++
 rtl/multi_cycle_ctrl.sv | 155 +++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: opcodes, FSM states,
// opcode classes, ALUOp / PCSrc / RegDst codes.
package ctrl_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU_R, CL_ALU_I, CL_BR, CL_LS, CL_JMP, CL_HALT, CL_ILL
    } op_class_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;

    localparam logic [1:0] PC_4   = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_RS  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    localparam logic [1:0] RD_31 = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: class, ALUOp, ExtSel, ALUSrcB.
// CTRL_JAL_EN enables jr/jal; without it they decode as illegal.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int AOPW = 3
) (
    input  logic [OPW-1:0]  opcode,
    output op_class_t       cls,
    output logic [AOPW-1:0] aluop,
    output logic            ext_sel,
    output logic            alusrcb
);

    always_comb begin
        cls = CL_ILL;
        case (opcode)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT: cls = CL_ALU_R;
            OP_ADDI, OP_ORI:                       cls = CL_ALU_I;
            OP_BEQ, OP_BNE:                        cls = CL_BR;
            OP_SW, OP_LW:                          cls = CL_LS;
            OP_J:                                  cls = CL_JMP;
`ifdef CTRL_JAL_EN
            OP_JR, OP_JAL:                         cls = CL_JMP;
`endif
            OP_HALT:                               cls = CL_HALT;
            default:                               cls = CL_ILL;
        endcase
    end

    always_comb begin
        aluop = AOPW'(ALU_ADD);
        case (opcode)
            OP_SUB, OP_BEQ, OP_BNE: aluop = AOPW'(ALU_SUB);
            OP_OR, OP_ORI:          aluop = AOPW'(ALU_OR);
            OP_AND:                 aluop = AOPW'(ALU_AND);
            OP_SLT:                 aluop = AOPW'(ALU_SLT);
            default:                aluop = AOPW'(ALU_ADD);
        endcase
    end

    assign ext_sel = (opcode != OP_ORI);
    assign alusrcb = (opcode == OP_ADDI) || (opcode == OP_ORI) ||
                     (opcode == OP_SW)   || (opcode == OP_LW);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM (IF/ID/EXE/MEM/WB). Optional jr/jal support
// is selected by the CTRL_JAL_EN macro.
module multi_cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int AOPW = 3
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero,
    output logic            PCWre,
    output logic [1:0]      PCSrc,
    output logic            IRWre,
    output logic            ExtSel,
    output logic            ALUSrcB,
    output logic [AOPW-1:0] ALUOp,
    output logic            mRD,
    output logic            mWR,
    output logic            DBDataSrc,
    output logic            RegWre,
    output logic            WrRegDSrc,
    output logic [1:0]      RegDst,
    output logic [2:0]      state
);

    state_t          st, nxt;
    op_class_t       cls;
    logic [AOPW-1:0] dec_aluop;
    logic            dec_ext, dec_srcb, br_taken;

    ctrl_decode #(.OPW(OPW), .AOPW(AOPW)) u_dec (
        .opcode  (opcode),
        .cls     (cls),
        .aluop   (dec_aluop),
        .ext_sel (dec_ext),
        .alusrcb (dec_srcb)
    );

    assign br_taken = ((opcode == OP_BEQ) &&  zero) ||
                      ((opcode == OP_BNE) && !zero);
    assign state    = st;

    always_ff @(posedge CLK) begin
        if (!Reset) st <= S_IF;
        else        st <= nxt;
    end

    always_comb begin
        nxt       = st;
        PCWre     = 1'b0;
        PCSrc     = PC_4;
        IRWre     = 1'b0;
        ExtSel    = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = AOPW'(ALU_ADD);
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        RegWre    = 1'b0;
        WrRegDSrc = 1'b0;
        RegDst    = RD_31;

        // Operand controls are steady from decode until the instruction retires.
        if (st != S_IF) begin
            ExtSel  = dec_ext;
            ALUSrcB = dec_srcb;
            ALUOp   = dec_aluop;
        end

        case (st)
            S_IF: begin
                IRWre = 1'b1;
                nxt   = S_ID;
            end
            S_ID: begin
                case (cls)
                    CL_ALU_R, CL_ALU_I: nxt = S_EXE_AL;
                    CL_BR:              nxt = S_EXE_BR;
                    CL_LS:              nxt = S_EXE_LS;
                    CL_JMP: begin
                        PCWre = 1'b1;
                        PCSrc = PC_JMP;
                        nxt   = S_IF;
`ifdef CTRL_JAL_EN
                        if (opcode == OP_JR) PCSrc = PC_RS;
                        if (opcode == OP_JAL) begin
                            RegWre    = 1'b1;
                            RegDst    = RD_31;
                            WrRegDSrc = 1'b0;
                        end
`endif
                    end
                    CL_HALT:            nxt = S_ID;
                    default: begin
                        PCWre = 1'b1;
                        nxt   = S_IF;
                    end
                endcase
            end
            S_EXE_AL: nxt = S_WB_AL;
            S_WB_AL: begin
                RegWre    = 1'b1;
                WrRegDSrc = 1'b1;
                RegDst    = (cls == CL_ALU_R) ? RD_RD : RD_RT;
                PCWre     = 1'b1;
                nxt       = S_IF;
            end
            S_EXE_BR: begin
                PCWre = 1'b1;
                PCSrc = br_taken ? PC_BR : PC_4;
                nxt   = S_IF;
            end
            S_EXE_LS: nxt = S_MEM;
            S_MEM: begin
                if (opcode == OP_SW) begin
                    mWR   = 1'b1;
                    PCWre = 1'b1;
                    nxt   = S_IF;
                end else begin
                    mRD = 1'b1;
                    nxt = S_WB_LD;
                end
            end
            S_WB_LD: begin
                mRD       = 1'b1;
                DBDataSrc = 1'b1;
                RegWre    = 1'b1;
                WrRegDSrc = 1'b1;
                RegDst    = RD_RT;
                PCWre     = 1'b1;
                nxt       = S_IF;
            end
            default: nxt = S_IF;
        endcase

        // While reset is held the outputs look like IF so no write escapes.
        if (!Reset) begin
            PCWre     = 1'b0;
            PCSrc     = PC_4;
            IRWre     = 1'b1;
            ExtSel    = 1'b0;
            ALUSrcB   = 1'b0;
            ALUOp     = AOPW'(ALU_ADD);
            mRD       = 1'b0;
            mWR       = 1'b0;
            DBDataSrc = 1'b0;
            RegWre    = 1'b0;
            WrRegDSrc = 1'b0;
            RegDst    = RD_31;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: per-cycle check against a phase-based model of
// each instruction, plus literal per-instruction traces.
module tb_multi_cycle_ctrl;

    logic       CLK = 1'b0, Reset, zero;
    logic [5:0] opcode;
    logic       PCWre, IRWre, ExtSel, ALUSrcB, mRD, mWR, DBDataSrc, RegWre, WrRegDSrc;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp, state;

    int n_chk = 0, n_fail = 0;

    multi_cycle_ctrl dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .ExtSel(ExtSel),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
        .DBDataSrc(DBDataSrc), .RegWre(RegWre), .WrRegDSrc(WrRegDSrc),
        .RegDst(RegDst), .state(state)
    );

    always #5 CLK = ~CLK;

    localparam int K_R = 0, K_I = 1, K_BR = 2, K_SW = 3, K_LW = 4, K_J = 5, K_H = 6, K_X = 7;

    function automatic int klass(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b010000, 6'b010001, 6'b100110: return K_R;
            6'b000010, 6'b010010: return K_I;
            6'b110100, 6'b110101: return K_BR;
            6'b110000: return K_SW;
            6'b110001: return K_LW;
            6'b111000: return K_J;
`ifdef CTRL_JAL_EN
            6'b111001, 6'b111010: return K_J;
`endif
            6'b111111: return K_H;
            default: return K_X;
        endcase
    endfunction

    function automatic int seq_len(input int k);
        case (k)
            K_R, K_I, K_SW: return 4;
            K_BR:           return 3;
            K_LW:           return 5;
            default:        return 2;
        endcase
    endfunction

    // State visited at each cycle of an instruction, by class.
    function automatic logic [2:0] seq_st(input int k, input int ph);
        logic [2:0] alu [4] = '{3'd0, 3'd1, 3'd6, 3'd7};
        logic [2:0] br  [3] = '{3'd0, 3'd1, 3'd5};
        if (k == K_R || k == K_I) return alu[ph];
        if (k == K_BR)            return br[ph];
        if (k == K_SW || k == K_LW) return 3'(ph);
        return (ph == 0) ? 3'd0 : 3'd1;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op);
        case (op)
            6'b000001, 6'b110100, 6'b110101: return 3'b001;
            6'b010000, 6'b010010:            return 3'b100;
            6'b010001:                       return 3'b101;
            6'b100110:                       return 3'b011;
            default:                         return 3'b000;
        endcase
    endfunction

    // {PCWre,PCSrc,IRWre,ExtSel,ALUSrcB,ALUOp,mRD,mWR,DBDataSrc,RegWre,WrRegDSrc,RegDst,state}
    function automatic logic [18:0] model_out(input logic [5:0] op, input int ph,
                                              input logic z, input logic rst_n);
        int k = klass(op);
        logic pcw = 0, irw = 0, ext = 0, srcb = 0, mrd = 0, mwr = 0, dbs = 0, rw = 0, wrs = 0;
        logic [1:0] pcs = 0, rd = 0;
        logic [2:0] aop = 0;
        logic [2:0] st = seq_st(k, ph);
        if (!rst_n || ph == 0) begin
            irw = 1;
        end else begin
            ext  = (op != 6'b010010);
            srcb = (op == 6'b000010) || (op == 6'b010010) || (op == 6'b110000) || (op == 6'b110001);
            aop  = alu_of(op);
            if (k != K_H && ph == seq_len(k) - 1) pcw = 1;
            case (k)
                K_R, K_I: if (ph == 3) begin rw = 1; wrs = 1; rd = (k == K_R) ? 2'd2 : 2'd1; end
                K_BR: if (ph == 2)
                    pcs = (((op == 6'b110100) && z) || ((op == 6'b110101) && !z)) ? 2'd1 : 2'd0;
                K_SW: if (ph == 3) mwr = 1;
                K_LW: begin
                    if (ph == 3) mrd = 1;
                    if (ph == 4) begin mrd = 1; dbs = 1; rw = 1; wrs = 1; rd = 2'd1; end
                end
                K_J: if (ph == 1) begin
                    pcs = (op == 6'b111001) ? 2'd2 : 2'd3;
                    if (op == 6'b111010) rw = 1;
                end
                default: ;
            endcase
        end
        return {pcw, pcs, irw, ext, srcb, aop, mrd, mwr, dbs, rw, wrs, rd, st};
    endfunction

    int   ph = 0;
    logic mvalid = 1'b0;

    always @(posedge CLK) begin
        if (!Reset) begin
            ph = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            if (klass(opcode) == K_H && ph == 1) ph = 1;
            else if (ph == seq_len(klass(opcode)) - 1) ph = 0;
            else ph = ph + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (mvalid)
            chk("cycle outputs",
                {13'd0, PCWre, PCSrc, IRWre, ExtSel, ALUSrcB, ALUOp, mRD, mWR,
                 DBDataSrc, RegWre, WrRegDSrc, RegDst, state},
                {13'd0, model_out(opcode, ph, zero, Reset)});
    end

    // Runs one instruction from IF and compares its traces with literals.
    task automatic run(input logic [5:0] op, input logic z, input int exp_len,
                       input logic [23:0] exp_st, input logic [7:0] exp_pw,
                       input logic [15:0] exp_ps, input logic [7:0] exp_rw, input string nm);
        logic [23:0] st_tr = '0;
        logic [15:0] ps_tr = '0;
        logic [7:0]  pw_tr = '0, rw_tr = '0;
        int len = 0;
        opcode = op;
        zero   = z;
        do begin
            st_tr = {st_tr[20:0], state};
            pw_tr = {pw_tr[6:0], PCWre};
            ps_tr = {ps_tr[13:0], PCSrc};
            rw_tr = {rw_tr[6:0], RegWre};
            len++;
            @(posedge CLK); #1;
        end while (state != 3'd0 && len < 10);
        chk({nm, " cycles"}, len, exp_len);
        chk({nm, " states"}, {8'd0, st_tr}, {8'd0, exp_st});
        chk({nm, " PCWre"}, {24'd0, pw_tr}, {24'd0, exp_pw});
        chk({nm, " PCSrc"}, {16'd0, ps_tr}, {16'd0, exp_ps});
        chk({nm, " RegWre"}, {24'd0, rw_tr}, {24'd0, exp_rw});
    endtask

    initial begin
        Reset = 1'b0; opcode = 6'b000000; zero = 1'b0;
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b1;
        chk("reset state", {29'd0, state}, 32'd0);
        chk("reset IRWre", {31'd0, IRWre}, 32'd1);
        chk("reset PCWre", {31'd0, PCWre}, 32'd0);

        run(6'b000000, 0, 4, 24'o0167, 8'b0001, 16'h0, 8'b0001, "add");
        run(6'b000001, 1, 4, 24'o0167, 8'b0001, 16'h0, 8'b0001, "sub");
        run(6'b000010, 0, 4, 24'o0167, 8'b0001, 16'h0, 8'b0001, "addi");
        run(6'b010000, 0, 4, 24'o0167, 8'b0001, 16'h0, 8'b0001, "or");
        run(6'b010001, 0, 4, 24'o0167, 8'b0001, 16'h0, 8'b0001, "and");
        run(6'b010010, 0, 4, 24'o0167, 8'b0001, 16'h0, 8'b0001, "ori");
        run(6'b100110, 0, 4, 24'o0167, 8'b0001, 16'h0, 8'b0001, "slt");
        run(6'b110000, 0, 4, 24'o0123, 8'b0001, 16'h0, 8'b0000, "sw");
        run(6'b110001, 0, 5, 24'o01234, 8'b00001, 16'h0, 8'b00000 | 8'b1, "lw");
        run(6'b110100, 1, 3, 24'o015, 8'b001, 16'b000001, 8'b0, "beq taken");
        run(6'b110100, 0, 3, 24'o015, 8'b001, 16'b000000, 8'b0, "beq not");
        run(6'b110101, 1, 3, 24'o015, 8'b001, 16'b000000, 8'b0, "bne not");
        run(6'b110101, 0, 3, 24'o015, 8'b001, 16'b000001, 8'b0, "bne taken");
        run(6'b111000, 0, 2, 24'o01, 8'b01, 16'b0011, 8'b0, "j");
`ifdef CTRL_JAL_EN
        run(6'b111001, 0, 2, 24'o01, 8'b01, 16'b0010, 8'b00, "jr");
        run(6'b111010, 0, 2, 24'o01, 8'b01, 16'b0011, 8'b01, "jal");
`else
        run(6'b111001, 0, 2, 24'o01, 8'b01, 16'b0000, 8'b00, "jr");
        run(6'b111010, 0, 2, 24'o01, 8'b01, 16'b0000, 8'b00, "jal");
`endif
        run(6'b000111, 0, 2, 24'o01, 8'b01, 16'b0000, 8'b00, "illegal");

        // Reset asserted in EXE_LS of a lw: outputs fall back to IF, next edge is IF.
        opcode = 6'b110001;
        repeat (2) begin @(posedge CLK); #1; end
        chk("lw mid state", {29'd0, state}, 32'd2);
        Reset = 1'b0;
        #1 chk("mid-reset IRWre", {31'd0, IRWre}, 32'd1);
        chk("mid-reset ALUSrcB", {31'd0, ALUSrcB}, 32'd0);
        @(posedge CLK); #1;
        chk("abort state", {29'd0, state}, 32'd0);
        Reset = 1'b1;

        // halt sits in ID until reset.
        opcode = 6'b111111;
        @(posedge CLK); #1;
        for (int i = 0; i < 20; i++) begin
            chk("halt state", {29'd0, state}, 32'd1);
            chk("halt PCWre", {31'd0, PCWre}, 32'd0);
            @(posedge CLK); #1;
        end
        Reset = 1'b0;
        @(posedge CLK); #1;
        chk("halt reset", {29'd0, state}, 32'd0);
        Reset = 1'b1;
        run(6'b000000, 0, 4, 24'o0167, 8'b0001, 16'h0, 8'b0001, "add after halt");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
